bar_scheduler: RTL and testbench

BAR_SCHEDULER -- requirements
Module: bar_scheduler

---
 rtl/bar_pkg.sv | 16 +
 rtl/bar_rr_arbiter.sv | 24 ++
 rtl/bar_scheduler.sv | 157 +++++++++++++++
 tb/tb_bar_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bar_pkg.sv
// Shared constants for the bar scheduler: default widths, channel count, bar height
// and the width of a channel index.
package bar_pkg;

    localparam int unsigned DEF_X_BITS = 13;
    localparam int unsigned DEF_Y_BITS = 13;
    localparam int unsigned DEF_N_BARS = 4;
    localparam int unsigned DEF_BAR_H  = 20;

    function automatic int unsigned id_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_BITS = id_bits(DEF_N_BARS);

endpackage

// File: rtl/bar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module bar_rr_arbiter
    import bar_pkg::*;
#(
    parameter int unsigned N = DEF_N_BARS
) (
    input  logic [N-1:0]          req,
    input  logic [id_bits(N)-1:0] ptr,
    output logic [N-1:0]          grant
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] gnt2;
    logic [N-1:0]   rot;
    logic [N-1:0]   first;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign req2  = {req, req} >> ptr;
    assign rot   = req2[N-1:0];
    assign first = rot & (-rot);
    assign gnt2  = {first, first} << ptr;
    assign grant = gnt2[2*N-1:N];

endmodule

// File: rtl/bar_scheduler.sv
// Frame-synchronous bar scheduler: arbitrated pending updates, per-frame commit with
// optional bounce animation, and a registered per-pixel hit test.
module bar_scheduler
    import bar_pkg::*;
#(
    parameter int unsigned X_BITS = DEF_X_BITS,
    parameter int unsigned Y_BITS = DEF_Y_BITS,
    parameter int unsigned N_BARS = DEF_N_BARS,
    parameter int unsigned BAR_H  = DEF_BAR_H
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vsync,
    input  logic [N_BARS-1:0]          req_valid,
    input  logic [N_BARS*X_BITS-1:0]   req_value,
    input  logic [N_BARS*Y_BITS-1:0]   req_y,
    output logic [N_BARS-1:0]          req_ready,
    input  logic [N_BARS-1:0]          mode,
    input  logic [X_BITS-1:0]          total_active_pix,
    input  logic [X_BITS-1:0]          x,
    input  logic [Y_BITS-1:0]          y,
    output logic                       draw,
    output logic [id_bits(N_BARS)-1:0] draw_id,
    output logic                       frame_tick
);

    localparam int unsigned IW = id_bits(N_BARS);

    logic              vsync_q;
    logic              tick_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     rr_ptr_d;
    logic [IW-1:0]     gnt_idx;
    logic [N_BARS-1:0] arb_req;
    logic [N_BARS-1:0] up_q;
    logic [N_BARS-1:0] up_d;
    logic [N_BARS-1:0] hit;
    logic              draw_q;
    logic              draw_d;
    logic [IW-1:0]     id_q;
    logic [IW-1:0]     id_d;

    logic [X_BITS-1:0] pend_len_q [N_BARS];
    logic [Y_BITS-1:0] pend_y_q   [N_BARS];
    logic [X_BITS-1:0] act_len_q  [N_BARS];
    logic [Y_BITS-1:0] act_y_q    [N_BARS];
    logic [X_BITS-1:0] cnt_q      [N_BARS];
    logic [X_BITS-1:0] cnt_d      [N_BARS];

    assign frame_tick = tick_q;
    assign draw       = draw_q;
    assign draw_id    = id_q;

    // No grants in the commit cycle, nor while reset is held.
    assign arb_req = req_valid & {N_BARS{reset_n & ~tick_q}};

    bar_rr_arbiter #(
        .N (N_BARS)
    ) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (req_ready)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(N_BARS); i++) begin
            if (req_ready[i]) gnt_idx = IW'(i);
        end
        rr_ptr_d = (gnt_idx == IW'(N_BARS - 1)) ? '0 : gnt_idx + IW'(1);
    end

    always_comb begin
        logic up_n;
        up_n = 1'b0;
        for (int i = 0; i < int'(N_BARS); i++) begin
            cnt_d[i] = cnt_q[i];
            up_d[i]  = up_q[i];
            if (total_active_pix == '0) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] > total_active_pix) begin
                cnt_d[i] = total_active_pix;
                up_d[i]  = 1'b0;
            end else begin
                up_n = up_q[i];
                if (cnt_q[i] == '0) begin
                    up_n = 1'b1;
                end else if (cnt_q[i] == total_active_pix) begin
                    up_n = 1'b0;
                end
                up_d[i]  = up_n;
                cnt_d[i] = up_n ? cnt_q[i] + X_BITS'(1) : cnt_q[i] - X_BITS'(1);
            end
        end
    end

    always_comb begin
        hit    = '0;
        draw_d = 1'b0;
        id_d   = '0;
        for (int i = 0; i < int'(N_BARS); i++) begin
            // Bottom edge is computed one bit wider so bars near the last line never wrap.
            hit[i] = (x <= act_len_q[i]) && (y >= act_y_q[i]) &&
                     ({1'b0, y} <= ({1'b0, act_y_q[i]} + (Y_BITS + 1)'(BAR_H)));
        end
        for (int i = int'(N_BARS) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                draw_d = 1'b1;
                id_d   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q  <= 1'b0;
            tick_q   <= 1'b0;
            rr_ptr_q <= '0;
            draw_q   <= 1'b0;
            id_q     <= '0;
            up_q     <= '1;
            for (int i = 0; i < int'(N_BARS); i++) begin
                pend_len_q[i] <= '0;
                pend_y_q[i]   <= '0;
                act_len_q[i]  <= '0;
                act_y_q[i]    <= '0;
                cnt_q[i]      <= '0;
            end
        end else begin
            vsync_q <= vsync;
            tick_q  <= vsync & ~vsync_q;
            draw_q  <= draw_d;
            id_q    <= id_d;
            if (tick_q) begin
                for (int i = 0; i < int'(N_BARS); i++) begin
                    act_y_q[i] <= pend_y_q[i];
                    if (mode[i]) begin
                        act_len_q[i] <= cnt_d[i];
                        cnt_q[i]     <= cnt_d[i];
                        up_q[i]      <= up_d[i];
                    end else begin
                        act_len_q[i] <= pend_len_q[i];
                    end
                end
            end else if (|req_ready) begin
                for (int i = 0; i < int'(N_BARS); i++) begin
                    if (req_ready[i]) begin
                        pend_len_q[i] <= req_value[i*X_BITS +: X_BITS];
                        pend_y_q[i]   <= req_y[i*Y_BITS +: Y_BITS];
                    end
                end
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

endmodule

// File: tb/tb_bar_scheduler.sv
// Bench for bar_scheduler: directed scenarios plus random traffic, all compared each
// cycle against a frame-level behavioural model.
module tb_bar_scheduler;

    localparam int XB = 13;
    localparam int YB = 13;
    localparam int NB = 4;
    localparam int BH = 20;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             vsync = 1'b0;
    logic [NB-1:0]    req_valid = '0;
    logic [NB*XB-1:0] req_value = '0;
    logic [NB*YB-1:0] req_y = '0;
    logic [NB-1:0]    req_ready;
    logic [NB-1:0]    mode = '0;
    logic [XB-1:0]    total_active_pix = '0;
    logic [XB-1:0]    x = '0;
    logic [YB-1:0]    y = '0;
    logic             draw;
    logic [1:0]       draw_id;
    logic             frame_tick;

    bar_scheduler #(
        .X_BITS (XB),
        .Y_BITS (YB),
        .N_BARS (NB),
        .BAR_H  (BH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .vsync            (vsync),
        .req_valid        (req_valid),
        .req_value        (req_value),
        .req_y            (req_y),
        .req_ready        (req_ready),
        .mode             (mode),
        .total_active_pix (total_active_pix),
        .x                (x),
        .y                (y),
        .draw             (draw),
        .draw_id          (draw_id),
        .frame_tick       (frame_tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: what each channel holds, in plain integers.
    int m_pend_len [NB];
    int m_pend_y   [NB];
    int m_act_len  [NB];
    int m_act_y    [NB];
    int m_cnt      [NB];
    int m_up       [NB];
    int m_rr, m_vs, m_tick, m_draw, m_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_pend_len[i] = 0; m_pend_y[i] = 0; m_act_len[i] = 0; m_act_y[i] = 0;
            m_cnt[i] = 0; m_up[i] = 1;
        end
        m_rr = 0; m_vs = 0; m_tick = 0; m_draw = 0; m_id = 0;
    endtask

    function automatic int model_grant();
        if (m_tick != 0) return -1;
        for (int k = 0; k < NB; k++) begin
            if (req_valid[(m_rr + k) % NB]) return (m_rr + k) % NB;
        end
        return -1;
    endfunction

    function automatic bit model_hit(input int i);
        return (int'(x) <= m_act_len[i]) && (int'(y) >= m_act_y[i]) &&
               (int'(y) <= m_act_y[i] + BH);
    endfunction

    task automatic model_bounce(input int i);
        int tap;
        tap = int'(total_active_pix);
        if (tap == 0) begin
            m_cnt[i] = 0;
        end else if (m_cnt[i] > tap) begin
            m_cnt[i] = tap;
            m_up[i]  = 0;
        end else begin
            if (m_cnt[i] == 0) m_up[i] = 1;
            else if (m_cnt[i] == tap) m_up[i] = 0;
            m_cnt[i] = m_cnt[i] + ((m_up[i] != 0) ? 1 : -1);
        end
    endtask

    task automatic model_step();
        int g, nd, nid;
        g = model_grant();
        nd = 0; nid = 0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (model_hit(i)) begin nd = 1; nid = i; end
        end
        if (m_tick != 0) begin
            for (int i = 0; i < NB; i++) begin
                m_act_y[i] = m_pend_y[i];
                if (mode[i]) begin
                    model_bounce(i);
                    m_act_len[i] = m_cnt[i];
                end else begin
                    m_act_len[i] = m_pend_len[i];
                end
            end
        end else if (g >= 0) begin
            m_pend_len[g] = int'(req_value[g*XB +: XB]);
            m_pend_y[g]   = int'(req_y[g*YB +: YB]);
            m_rr = (g + 1) % NB;
        end
        m_tick = (vsync && m_vs == 0) ? 1 : 0;
        m_vs   = vsync ? 1 : 0;
        m_draw = nd;
        m_id   = nid;
    endtask

    task automatic compare();
        int g;
        logic [NB-1:0] exp_ready;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("frame_tick", 32'(frame_tick), m_tick);
        check("draw", 32'(draw), m_draw);
        check("draw_id", 32'(draw_id), m_id);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ch(input int i, input int v, input int yy);
        req_valid = '0;
        req_valid[i] = 1'b1;
        req_value[i*XB +: XB] = XB'(v);
        req_y[i*YB +: YB] = YB'(yy);
        cycle();
        req_valid = '0;
    endtask

    task automatic frame();
        vsync = 1'b1;
        cycle();
        cycle();
        vsync = 1'b0;
        cycle();
    endtask

    task automatic probe(input string name, input int xx, input int yy, input int ed,
                         input int eid);
        x = XB'(xx);
        y = YB'(yy);
        cycle();
        check(name, 32'(draw), ed);
        if (ed != 0) check(name, 32'(draw_id), eid);
    endtask

    int bounce_exp [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

    initial begin
        model_reset();
        req_valid = '1;
        #1;
        check("reset_ready", 32'(req_ready), 0);
        check("reset_draw", 32'(draw), 0);
        check("reset_id", 32'(draw_id), 0);
        check("reset_tick", 32'(frame_tick), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_valid = '0;
        x = 13'd500;
        y = 13'd500;
        cycle();

        // Two continuous requesters alternate.
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_alternate", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
            cycle();
        end
        req_valid = '0;

        // Mid-frame write is invisible until the commit.
        write_ch(1, 100, 50);
        probe("pre_commit", 100, 70, 0, 0);
        frame();
        probe("hit_corner", 100, 70, 1, 1);
        probe("miss_x", 101, 70, 0, 0);
        probe("miss_y", 100, 71, 0, 0);

        // Request arriving in the commit cycle waits one cycle and a whole frame.
        vsync = 1'b1;
        cycle();
        req_valid = 4'b1000;
        req_value[3*XB +: XB] = 13'd777;
        req_y[3*YB +: YB] = 13'd200;
        #1;
        check("tick_ready_zero", 32'(req_ready), 0);
        check("tick_high", 32'(frame_tick), 1);
        cycle();
        #1;
        check("ready_after_tick", 32'(req_ready), 32'h8);
        cycle();
        req_valid = '0;
        vsync = 1'b0;
        probe("ch3_not_yet", 777, 200, 0, 0);
        frame();
        probe("ch3_committed", 777, 200, 1, 3);

        // Bounce animation on channel 0.
        write_ch(0, 0, 500);
        mode = 4'b0001;
        total_active_pix = 13'd3;
        for (int f = 0; f < 8; f++) begin
            frame();
            check("bounce_model", m_cnt[0], bounce_exp[f]);
            probe("bounce_len_in", bounce_exp[f], 500, 1, 0);
            probe("bounce_len_out", bounce_exp[f] + 1, 500, 0, 0);
        end
        mode = '0;

        // Priority and no-wrap at the bottom of the y range.
        write_ch(0, 50, 300);
        write_ch(3, 50, 300);
        write_ch(2, 4000, 8185);
        frame();
        probe("overlap_lowest", 10, 310, 1, 0);
        probe("no_wrap", 10, 5, 0, 0);
        probe("high_bar", 10, 8190, 1, 2);

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            req_valid = NB'($urandom);
            for (int i = 0; i < NB; i++) begin
                req_value[i*XB +: XB] = XB'($urandom_range(0, 300));
                req_y[i*YB +: YB] = YB'($urandom_range(0, 400));
            end
            x = XB'($urandom_range(0, 320));
            y = YB'($urandom_range(0, 440));
            if ($urandom_range(0, 11) == 0) vsync = ~vsync;
            if ($urandom_range(0, 79) == 0) mode = NB'($urandom);
            if ($urandom_range(0, 149) == 0) total_active_pix = XB'($urandom_range(0, 8));
            cycle();
        end

        // Reset mid-frame discards the pending write.
        req_valid = '0;
        vsync = 1'b0;
        mode = '0;
        cycle();
        write_ch(1, 250, 60);
        req_valid = '1;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_draw", 32'(draw), 0);
        check("rst_id", 32'(draw_id), 0);
        check("rst_tick", 32'(frame_tick), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_valid = '0;
        frame();
        probe("rst_ch1_gone", 250, 60, 0, 0);
        probe("rst_zero_bar", 0, 10, 1, 0);
        probe("rst_zero_len", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
